execute_md: RTL
===============

# execute_md

Parametrised execute stage for the RISC-V pipeline, sitting between decode and memory. It replaces the single-cycle execute with an XLEN-generic stage that adds an iterative RV32M/RV64M multiply/divide unit. While a multi-cycle operation runs it stalls decode through a ready/valid handshake. Single-cycle ALU operations, forwarding and branch resolution keep their existing one-cycle behaviour.

## Interface
Parameters:
- XLEN, 32: datapath width (32 or 64).
- CNT_W, $clog2(XLEN+1): iteration counter width.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts; equals (state==IDLE).
- alu_op  in  4  existing alu encoding.
- is_md  in  1  instruction is M-extension.
- md_op  in  3  M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- funct3  in  3  branch condition.
- is_branch  in  1  branch instruction.
- use_pc, use_imm  in  1 each  ALU operand selects.
- pc_value, immediate_sext, rs1_data, rs2_data  in  XLEN each  operands.
- rs1s, rs2s  in  2 each  bypass select: REG, MEM, WB.
- bp_mem, bp_wb  in  XLEN each  bypass values.
- rd  in  5  destination register.
- reg_write, mem_read, mem_write  in  1 each  control.
- out_valid  out  1  registered result valid.
- alu_result, write_data  out  XLEN each  to memory stage.
- rd_o, reg_write_o, mem_read_o, mem_write_o  out  registered control.
- pc_reset  out  1  registered branch taken.
- busy  out  1  MD unit iterating.

## Operation
- Forwarding: src = MEM ? bp_mem : WB ? bp_wb : rsN_data. It applies to the ALU, write_data, the branch compare and the MD operands.
- A handshake fires when in_valid && in_ready.
- **Non-MD handshake:** computes the ALU result (in1 = use_pc ? pc : rs1; in2 = use_imm ? imm : rs2) and registers all outputs. out_valid=1. pc_reset = is_branch && compare(rs1, rs2, funct3).
- **MD handshake:**
  - Latches the forwarded operands, md_op and control.
  - FSM goes IDLE -> BUSY and the counter loads XLEN.
  - Operands are converted to magnitudes per signedness. Sign fix-up is applied at the end.
- **Multiply:** radix-2 shift-add over XLEN iterations into a 2*XLEN accumulator. MUL returns the low half; the MULH* variants return the high half.
- **Divide:** restoring, XLEN iterations.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
  - Both special cases take the same latency as a normal divide.
- **BUSY:** one iteration per edge. When the counter reaches 0, the next edge registers the result with out_valid=1, and the FSM returns to IDLE.
- Output bubble: out_valid=0, reg_write_o=0, mem_write_o=0, mem_read_o=0, pc_reset=0. It is produced every cycle with no handshake, including all BUSY cycles.
- Reset, including mid-operation: FSM to IDLE, counter 0, accumulators discarded. All outputs are 0 and in_ready=1 on the cycle after the reset edge.

## Timing
- ALU/branch: accept at edge N; outputs valid after edge N.
- MD: accept at edge N.
  - busy=1 and in_ready=0 after edge N through edge N+XLEN.
  - Result registered at edge N+XLEN+1.
  - Next accept at edge N+XLEN+2 at the earliest.
- Bypass inputs are sampled only on the accept edge; later changes are ignored.
- in_valid while in_ready=0 is not accepted; decode holds its instruction.

## Configuration
- EXECUTE_MD_EN defined: MD unit, FSM and stall are built.
- Without EXECUTE_MD_EN:
  - in_ready is tied to 1 and busy to 0.
  - is_md instructions complete in one cycle with alu_result=0, and other controls pass through.
  - No multiplier/divider logic is synthesised.

## Test plan
- ADDI, rs1=5, imm=7, no bypass -> alu_result=12 after one edge; out_valid=1.
- ADD with rs1s=MEM, bp_mem=0x10, rs2=3 -> 0x13. BEQ with rs1s=WB, bp_wb=rs2 value -> pc_reset=1.
- MUL 0xFFFFFFFF*2 and MULHU same operands (XLEN=32) -> 0xFFFFFFFE and 0x00000001.
  - Timing: in_ready low for 33 cycles; out_valid exactly once, at accept+33.
- DIV -20/3 -> -6; REM -> -2. DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0.
- rst asserted at BUSY iteration 10 -> next cycle in_ready=1 and all outputs 0. A following ADD completes normally.
- Build without EXECUTE_MD_EN: DIV accepted back-to-back with an ADD, no stall, DIV alu_result=0.

Source files
------------

// File: rtl/execute_md.sv
// execute_md: RISC-V execute stage with single-cycle ALU, forwarding and branch resolution.
// Optional iterative RV32M/RV64M multiply/divide unit with decode stall, built when EXECUTE_MD_EN is defined.
module execute_md #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic            is_md,
  input  logic [2:0]      md_op,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            use_pc,
  input  logic            use_imm,
  input  logic [XLEN-1:0] pc_value,
  input  logic [XLEN-1:0] immediate_sext,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [1:0]      rs1s,
  input  logic [1:0]      rs2s,
  input  logic [XLEN-1:0] bp_mem,
  input  logic [XLEN-1:0] bp_wb,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic [4:0]      rd_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            pc_reset,
  output logic            busy
);
  localparam int unsigned SH_W = $clog2(XLEN);

  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel, input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] mem_v, input logic [XLEN-1:0] wb_v);
    logic [XLEN-1:0] r;
    r = reg_v;
    if (sel == SEL_MEM) r = mem_v;
    else if (sel == SEL_WB) r = wb_v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    logic [XLEN-1:0] r;
    sh = b[SH_W-1:0];
    r  = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << sh;
      ALU_SLT:  r = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: r = XLEN'(a < b);
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $unsigned($signed(a) >>> sh);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_PASS: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_cmp(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic t;
    t = 1'b0;
    case (f)
      BR_EQ:   t = (a == b);
      BR_NE:   t = (a != b);
      BR_LT:   t = ($signed(a) < $signed(b));
      BR_GE:   t = ($signed(a) >= $signed(b));
      BR_LTU:  t = (a < b);
      BR_GEU:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [XLEN-1:0] src1_c, src2_c, alu_res_c;
  logic            br_taken_c, fire_c;

  // Next values for the registered outputs
  logic            valid_d, rw_d, mr_d, mw_d, pcr_d;
  logic [XLEN-1:0] res_d, wdata_d;
  logic [4:0]      rd_d;

  assign src1_c     = fwd_sel(rs1s, rs1_data, bp_mem, bp_wb);
  assign src2_c     = fwd_sel(rs2s, rs2_data, bp_mem, bp_wb);
  assign alu_res_c  = alu_calc(alu_op, use_pc ? pc_value : src1_c, use_imm ? immediate_sext : src2_c);
  assign br_taken_c = is_branch && br_cmp(funct3, src1_c, src2_c);
  assign fire_c     = in_valid && in_ready;

`ifdef EXECUTE_MD_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d, dvd_q, dvd_d, wd_q, wd_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, div0_q, div0_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic            md_rw_q, md_rw_d, md_mr_q, md_mr_d, md_mw_q, md_mw_d;

  logic            a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic [XLEN:0]   mul_sum_c, div_rem_c, div_diff_c;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0] quo_c, rem_c, md_res_c;

  // Magnitudes and signs of the forwarded operands for the selected M op
  assign a_sgn_c = (md_op == MD_MULH) || (md_op == MD_MULHSU) || (md_op == MD_DIV) || (md_op == MD_REM);
  assign b_sgn_c = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
  assign a_neg_c = a_sgn_c && src1_c[XLEN-1];
  assign b_neg_c = b_sgn_c && src2_c[XLEN-1];
  assign a_mag_c = a_neg_c ? -src1_c : src1_c;
  assign b_mag_c = b_neg_c ? -src2_c : src2_c;

  // One shift-add multiply step, one restoring divide step
  assign mul_sum_c  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign div_rem_c  = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign div_diff_c = div_rem_c - {1'b0, opnd_q};

  assign prod_c = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_c  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_c  = neg_q ? -acc_hi_q : acc_hi_q;

  // Final sign fix-up and divide-by-zero override; signed overflow falls out of the magnitudes
  always_comb begin
    md_res_c = '0;
    case (op_q)
      MD_MUL:                      md_res_c = prod_c[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res_c = prod_c[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             md_res_c = div0_q ? '1 : quo_c;
      default:                     md_res_c = div0_q ? dvd_q : rem_c;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    wd_d     = wd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    md_rd_d  = md_rd_q;
    md_rw_d  = md_rw_q;
    md_mr_d  = md_mr_q;
    md_mw_d  = md_mw_q;
    valid_d  = 1'b0;
    rw_d     = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    pcr_d    = 1'b0;
    res_d    = alu_result;
    wdata_d  = write_data;
    rd_d     = rd_o;
    case (state_q)
      ST_IDLE: begin
        if (fire_c && is_md) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_W'(XLEN);
          acc_hi_d = '0;
          acc_lo_d = a_mag_c;
          opnd_d   = b_mag_c;
          dvd_d    = src1_c;
          wd_d     = src2_c;
          op_d     = md_op;
          neg_d    = (md_op[2] && md_op[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
          div0_d   = md_op[2] && (src2_c == '0);
          md_rd_d  = rd;
          md_rw_d  = reg_write;
          md_mr_d  = mem_read;
          md_mw_d  = mem_write;
        end else if (fire_c) begin
          valid_d = 1'b1;
          res_d   = alu_res_c;
          wdata_d = src2_c;
          rd_d    = rd;
          rw_d    = reg_write;
          mr_d    = mem_read;
          mw_d    = mem_write;
          pcr_d   = br_taken_c;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (op_q[2]) begin
            acc_hi_d = div_diff_c[XLEN] ? div_rem_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
            acc_lo_d = {acc_lo_q[XLEN-2:0], ~div_diff_c[XLEN]};
          end else begin
            acc_hi_d = mul_sum_c[XLEN:1];
            acc_lo_d = {mul_sum_c[0], acc_lo_q[XLEN-1:1]};
          end
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          res_d   = md_res_c;
          wdata_d = wd_q;
          rd_d    = md_rd_q;
          rw_d    = md_rw_q;
          mr_d    = md_mr_q;
          mw_d    = md_mw_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      wd_q     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      md_rd_q  <= '0;
      md_rw_q  <= 1'b0;
      md_mr_q  <= 1'b0;
      md_mw_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      wd_q     <= wd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      md_rd_q  <= md_rd_d;
      md_rw_q  <= md_rw_d;
      md_mr_q  <= md_mr_d;
      md_mw_q  <= md_mw_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_BUSY);
`else
  // M instructions retire in one cycle with a zero result; md_op has no consumer here
  logic unused_md;
  assign unused_md = ^{md_op, {CNT_W{1'b0}}};

  always_comb begin
    valid_d = 1'b0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    pcr_d   = 1'b0;
    res_d   = alu_result;
    wdata_d = write_data;
    rd_d    = rd_o;
    if (fire_c) begin
      valid_d = 1'b1;
      res_d   = is_md ? '0 : alu_res_c;
      wdata_d = src2_c;
      rd_d    = rd;
      rw_d    = reg_write;
      mr_d    = mem_read;
      mw_d    = mem_write;
      pcr_d   = br_taken_c;
    end
  end

  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  // Registered outputs toward the memory stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_result  <= '0;
      write_data  <= '0;
      rd_o        <= '0;
      reg_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      pc_reset    <= 1'b0;
    end else begin
      out_valid   <= valid_d;
      alu_result  <= res_d;
      write_data  <= wdata_d;
      rd_o        <= rd_d;
      reg_write_o <= rw_d;
      mem_read_o  <= mr_d;
      mem_write_o <= mw_d;
      pc_reset    <= pcr_d;
    end
  end

endmodule
